// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, grouped carry-lookahead
// add/sub, {V,C,N,Z} status flags and a sticky HALT that blocks further input.
module alu_pipe #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned GROUP = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic             halted
);

    localparam int NumGroups = int'(WIDTH / GROUP);
    localparam int Grp       = int'(GROUP);

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpNot  = 4'd2;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpMov  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSub  = 4'd7;
    localparam logic [3:0] OpAddi = 4'd8;
    localparam logic [3:0] OpSubi = 4'd9;
    localparam logic [3:0] OpMovi = 4'd10;
    localparam logic [3:0] OpNop  = 4'd11;
    localparam logic [3:0] OpHalt = 4'd15;

    // Stage 1 state
    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_g_q, s1_p_q;
    logic             s1_cin_q;

    // Stage 2 state
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_out_q;
    logic [3:0]       s2_flags_q;
    logic             s2_illegal_q;
    logic             s2_halt_q;

    logic             halt_pending_q, halted_q;

    logic             advance, accept, is_sub;
    logic [WIDTH-1:0] b_eff;

    assign advance  = !s2_valid_q || out_ready;
    // Gated by rst_n so in_ready reads 0 while reset is held.
    assign in_ready = rst_n && advance && !halt_pending_q;
    assign accept   = in_valid && in_ready;
    assign is_sub   = (opcode == OpSub) || (opcode == OpSubi);
    assign b_eff    = is_sub ? ~b : b;

    // Stage 1: capture operands, inverted subtrahend and generate/propagate terms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_cin_q   <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_op_q  <= opcode;
                s1_a_q   <= a;
                s1_b_q   <= b_eff;
                s1_g_q   <= a & b_eff;
                s1_p_q   <= a ^ b_eff;
                s1_cin_q <= is_sub;
            end
        end
    end

    logic [WIDTH:0]   carry;
    logic             cla, term;
    logic [WIDTH-1:0] res_d;
    logic             c_d, v_d, ill_d;
    logic [3:0]       flags_d;

    // Stage 2 carry chain: lookahead inside each group, group carry-out ripples upward
    always_comb begin
        carry    = '0;
        carry[0] = s1_cin_q;
        cla      = 1'b0;
        term     = 1'b0;
        for (int gi = 0; gi < NumGroups; gi++) begin
            for (int k = 0; k < Grp; k++) begin
                // Full-propagate path from the group carry-in
                cla = carry[gi*Grp];
                for (int m = 0; m <= k; m++) begin
                    cla = cla & s1_p_q[gi*Grp+m];
                end
                // Generate at bit m, propagated through bits m+1..k
                for (int m = 0; m <= k; m++) begin
                    term = s1_g_q[gi*Grp+m];
                    for (int n = m + 1; n <= k; n++) begin
                        term = term & s1_p_q[gi*Grp+n];
                    end
                    cla = cla | term;
                end
                carry[gi*Grp+k+1] = cla;
            end
        end
    end

    // Stage 2 result select and flag generation
    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        ill_d = 1'b0;
        case (s1_op_q)
            OpAnd:  res_d = s1_a_q & s1_b_q;
            OpOr:   res_d = s1_a_q | s1_b_q;
            OpNot:  res_d = ~s1_a_q;
            OpAdd, OpAddi, OpSub, OpSubi: begin
                res_d = s1_p_q ^ carry[WIDTH-1:0];
                c_d   = carry[WIDTH];
                v_d   = carry[WIDTH] ^ carry[WIDTH-1];
            end
            OpMov:  res_d = s1_a_q;
            OpSll: begin
                res_d = {s1_a_q[WIDTH-2:0], 1'b0};
                c_d   = s1_a_q[WIDTH-1];
            end
            OpSrl: begin
                res_d = {1'b0, s1_a_q[WIDTH-1:1]};
                c_d   = s1_a_q[0];
            end
            OpMovi: res_d = s1_b_q;
            OpNop, OpHalt: res_d = '0;
            default: ill_d = 1'b1;
        endcase
        flags_d = {v_d, c_d, res_d[WIDTH-1], (res_d == '0)};
    end

    // Stage 2 registers; data holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_out_q     <= '0;
            s2_flags_q   <= '0;
            s2_illegal_q <= 1'b0;
            s2_halt_q    <= 1'b0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_out_q     <= res_d;
                s2_flags_q   <= flags_d;
                s2_illegal_q <= ill_d;
                s2_halt_q    <= (s1_op_q == OpHalt);
            end
        end
    end

    // Sticky halt: pending on HALT acceptance, halted when the HALT beat retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            if (accept && (opcode == OpHalt)) begin
                halt_pending_q <= 1'b1;
            end
            if (s2_valid_q && out_ready && s2_halt_q) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = s2_out_q;
    assign flags     = s2_flags_q;
    assign illegal   = s2_illegal_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=9, GROUP=3).
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] a = '0;
    logic [8:0] b = '0;
    logic [3:0] opcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out;
    logic [3:0] flags;
    logic       illegal;
    logic       halted;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(9), .GROUP(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .illegal   (illegal),
        .halted    (halted)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] out;
        logic [3:0] flags; // {V,C,N,Z}
        logic       ill;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int bp_sent, bp_got;

    // Offer MOVI beats b=1..4; check retired beats come out in order
    task automatic run_bp(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid = (bp_sent < 4);
            opcode   = 4'd10;
            a        = 9'h000;
            b        = 9'(bp_sent + 1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("bp_order", 32'(out), 32'(bp_got + 1));
                bp_got++;
            end
            if (in_valid && in_ready) bp_sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    int leaked, halt_seen, seen_at, stray;

    initial begin
        vecs[0]  = '{4'd3,  9'h1FF, 9'h001, 9'h000, 4'b0101, 1'b0}; // ADD wrap
        vecs[1]  = '{4'd3,  9'h0FF, 9'h001, 9'h100, 4'b1010, 1'b0}; // ADD signed ovf
        vecs[2]  = '{4'd7,  9'h005, 9'h007, 9'h1FE, 4'b0010, 1'b0}; // SUB borrow
        vecs[3]  = '{4'd9,  9'h007, 9'h005, 9'h002, 4'b0100, 1'b0}; // SUBI
        vecs[4]  = '{4'd0,  9'h0F0, 9'h03C, 9'h030, 4'b0000, 1'b0}; // AND
        vecs[5]  = '{4'd1,  9'h0F0, 9'h00F, 9'h0FF, 4'b0000, 1'b0}; // OR
        vecs[6]  = '{4'd2,  9'h0F0, 9'h000, 9'h10F, 4'b0010, 1'b0}; // NOT
        vecs[7]  = '{4'd5,  9'h101, 9'h000, 9'h002, 4'b0100, 1'b0}; // SLL
        vecs[8]  = '{4'd6,  9'h101, 9'h000, 9'h080, 4'b0100, 1'b0}; // SRL
        vecs[9]  = '{4'd10, 9'h1FF, 9'h0AA, 9'h0AA, 4'b0000, 1'b0}; // MOVI
        vecs[10] = '{4'd4,  9'h1A5, 9'h000, 9'h1A5, 4'b0010, 1'b0}; // MOV
        vecs[11] = '{4'd11, 9'h003, 9'h004, 9'h000, 4'b0001, 1'b0}; // NOP
        vecs[12] = '{4'd13, 9'h1FF, 9'h1FF, 9'h000, 4'b0001, 1'b1}; // reserved
        vecs[13] = '{4'd8,  9'h123, 9'h0DD, 9'h000, 4'b0101, 1'b0}; // ADDI wrap to 0
        vecs[14] = '{4'd7,  9'h100, 9'h001, 9'h0FF, 4'b1100, 1'b0}; // SUB signed ovf
        vecs[15] = '{4'd3,  9'h007, 9'h001, 9'h008, 4'b0000, 1'b0}; // carry across group
        vecs[16] = '{4'd7,  9'h0AA, 9'h0AA, 9'h000, 4'b0101, 1'b0}; // SUB equal

        // Reset values
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", 32'({out_valid, out, flags, illegal, halted}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Latency: two cycles from acceptance
        in_valid = 1'b1; opcode = 4'd3; a = 9'h010; b = 9'h020;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_not_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'({out_valid, out}), 32'({1'b1, 9'h030}));

        // Back-to-back stream of the whole table
        for (int n = 0; n < NV + 2; n++) begin
            @(posedge clk); #1;
            if (n >= 2) begin
                check($sformatf("vec%0d", n - 2),
                      32'({out_valid, out, flags, illegal}),
                      32'({1'b1, vecs[n-2].out, vecs[n-2].flags, vecs[n-2].ill}));
            end
            if (n < NV) begin
                in_valid = 1'b1;
                opcode   = vecs[n].op;
                a        = vecs[n].a;
                b        = vecs[n].b;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: only two beats fit, output holds
        bp_sent = 0; bp_got = 0;
        out_ready = 1'b0;
        run_bp(6);
        check("bp_accepted", 32'(bp_sent), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold", 32'({out_valid, out, flags}), 32'({1'b1, 9'h001, 4'b0000}));
        out_ready = 1'b1;
        run_bp(10);
        check("bp_all_out", 32'(bp_got), 32'd4);
        check("bp_all_in", 32'(bp_sent), 32'd4);

        // HALT blocks later ADDs
        in_valid = 1'b1; opcode = 4'd15; a = 9'h000; b = 9'h000;
        @(negedge clk);
        check("halt_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        opcode = 4'd3; a = 9'h001; b = 9'h001;
        leaked = 0; halt_seen = 0; seen_at = -10;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready) leaked++;
            if (c == seen_at + 1) check("halted_set", 32'(halted), 32'd1);
            if (out_valid) begin
                halt_seen++;
                seen_at = c;
                check("halt_beat", 32'({out, flags, illegal, halted}),
                      32'({9'h000, 4'b0001, 1'b0, 1'b0}));
            end
        end
        check("halt_no_accept", 32'(leaked), 32'd0);
        check("halt_one_beat", 32'(halt_seen), 32'd1);
        check("halt_sticky", 32'({halted, in_ready}), 32'b10);

        // Reset clears halt
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst2_clear", 32'({halted, in_ready, out_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst2_ready", 32'(in_ready), 32'd1);

        // Reserved opcode, then reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'd13; a = 9'h055; b = 9'h0AA;
        @(posedge clk); #1;
        opcode = 4'd3; a = 9'h001; b = 9'h001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("illegal_beat", 32'({out_valid, out, flags, illegal}),
              32'({1'b1, 9'h000, 4'b0001, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst3_outputs", 32'({out_valid, out, flags, illegal, halted}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("rst3_no_output", 32'(stray), 32'd0);
        check("rst3_ready", 32'({in_ready, out, illegal}), 32'({1'b1, 9'h000, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
